sobel_linebuf_ctrl: RTL and testbench

- Controller that sequences two external ram_1r1w_sync line buffers (buf0, buf1, each width_p pixels deep) for the Sobel front end.
- Accepts a raster pixel stream with valid/ready and writes each row into alternating buffers.
- Reads the two previous rows at the same column and emits one vertical 3-pixel column per input pixel (top = row r-2, mid = row r-1, bot = row r), with zero padding at the frame top. Downstream is the 3x3 window shifter.

---
 rtl/sobel_linebuf_ctrl.sv | 152 +++++++++++++++
 tb/tb_sobel_linebuf_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_linebuf_ctrl
//  Function : Sequences two alternating line buffers and emits one vertical
//             3-pixel column (rows r-2, r-1, r) per accepted input pixel.
//  Revision : 1.0  initial release
// ============================================================================
module sobel_linebuf_ctrl #(
    parameter int pix_w_p  = 8,
    parameter int width_p  = 640,
    parameter int height_p = 480
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [pix_w_p-1:0]          in_data_i,
    input  logic                        in_sof_i,
    output logic [$clog2(width_p)-1:0]  ram_rd_addr_o,
    input  logic [pix_w_p-1:0]          ram0_rd_data_i,
    input  logic [pix_w_p-1:0]          ram1_rd_data_i,
    output logic                        ram0_wr_valid_o,
    output logic                        ram1_wr_valid_o,
    output logic [$clog2(width_p)-1:0]  ram_wr_addr_o,
    output logic [pix_w_p-1:0]          ram_wr_data_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [pix_w_p-1:0]          out_top_o,
    output logic [pix_w_p-1:0]          out_mid_o,
    output logic [pix_w_p-1:0]          out_bot_o,
    output logic [$clog2(width_p)-1:0]  out_col_o,
    output logic [$clog2(height_p)-1:0] out_row_o,
    output logic                        out_eof_o
);
    localparam int C_COL_W = $clog2(width_p);
    localparam int C_ROW_W = $clog2(height_p);
    localparam logic [C_COL_W-1:0] C_LAST_COL = C_COL_W'(width_p - 1);
    localparam logic [C_ROW_W-1:0] C_LAST_ROW = C_ROW_W'(height_p - 1);
    localparam logic [C_ROW_W-1:0] C_ROW_TWO  = C_ROW_W'(2);

    logic [C_COL_W-1:0] r_col_cnt;
    logic [C_ROW_W-1:0] r_row_cnt;

    logic               r_s1_valid;
    logic [pix_w_p-1:0] r_s1_pix;
    logic [C_COL_W-1:0] r_s1_col;
    logic [C_ROW_W-1:0] r_s1_row;
    logic               r_s1_eof;

    logic               r_out_valid;
    logic [pix_w_p-1:0] r_top;
    logic [pix_w_p-1:0] r_mid;
    logic [pix_w_p-1:0] r_bot;
    logic [C_COL_W-1:0] r_col;
    logic [C_ROW_W-1:0] r_row;
    logic               r_eof;

    logic               w_advance;
    logic               w_in_ready;
    logic               w_accept;
    logic [C_COL_W-1:0] w_pix_col;
    logic [C_ROW_W-1:0] w_pix_row;
    logic               w_pix_eof;
    logic [pix_w_p-1:0] w_same_par;
    logic [pix_w_p-1:0] w_other_par;

    assign w_advance  = r_s1_valid & (~r_out_valid | out_ready_i);
    assign w_in_ready = ~r_s1_valid | w_advance;
    assign w_accept   = in_valid_i & w_in_ready;

    // start-of-frame overrides the running position for this pixel only
    assign w_pix_col = in_sof_i ? '0 : r_col_cnt;
    assign w_pix_row = in_sof_i ? '0 : r_row_cnt;
    assign w_pix_eof = (w_pix_col == C_LAST_COL) && (w_pix_row == C_LAST_ROW);

    // buffer of S1's own row parity still holds row r-2 until this edge's write
    assign w_same_par  = r_s1_row[0] ? ram1_rd_data_i : ram0_rd_data_i;
    assign w_other_par = r_s1_row[0] ? ram0_rd_data_i : ram1_rd_data_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (w_accept) begin
            if (w_pix_col == C_LAST_COL) begin
                r_col_cnt <= '0;
                r_row_cnt <= (w_pix_row == C_LAST_ROW) ? '0 : w_pix_row + 1'b1;
            end else begin
                r_col_cnt <= w_pix_col + 1'b1;
                r_row_cnt <= w_pix_row;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_s1_eof   <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_pix   <= in_data_i;
            r_s1_col   <= w_pix_col;
            r_s1_row   <= w_pix_row;
            r_s1_eof   <= w_pix_eof;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_out_valid <= 1'b0;
            r_top       <= '0;
            r_mid       <= '0;
            r_bot       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_eof       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= 1'b1;
            r_top       <= (r_s1_row >= C_ROW_TWO) ? w_same_par : '0;
            r_mid       <= (r_s1_row != '0) ? w_other_par : '0;
            r_bot       <= r_s1_pix;
            r_col       <= r_s1_col;
            r_row       <= r_s1_row;
            r_eof       <= r_s1_eof;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    // while stalled the read address parks on S1's column so the RAM output stays valid
    assign ram_rd_addr_o   = w_accept ? w_pix_col : r_s1_col;
    assign ram0_wr_valid_o = w_advance & ~r_s1_row[0];
    assign ram1_wr_valid_o = w_advance &  r_s1_row[0];
    assign ram_wr_addr_o   = r_s1_col;
    assign ram_wr_data_o   = r_s1_pix;

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_top_o   = r_top;
    assign out_mid_o   = r_mid;
    assign out_bot_o   = r_bot;
    assign out_col_o   = r_col;
    assign out_row_o   = r_row;
    assign out_eof_o   = r_eof;

endmodule
`default_nettype wire

// File: tb/tb_sobel_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_linebuf_ctrl
//  Function : Self-checking bench for sobel_linebuf_ctrl (4x4 frame, 8-bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sobel_linebuf_ctrl;
    localparam int C_PW = 8;
    localparam int C_W  = 4;
    localparam int C_H  = 4;

    typedef struct packed {
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
        logic [1:0] col;
        logic [1:0] row;
        logic       eof;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        exp_t       exp;
    } vec_t;

    logic            clk;
    logic            reset_ni;
    logic            in_valid;
    logic            in_ready;
    logic [C_PW-1:0] in_data;
    logic            in_sof;
    logic [1:0]      rd_addr;
    logic [C_PW-1:0] rd0;
    logic [C_PW-1:0] rd1;
    logic            wr0;
    logic            wr1;
    logic [1:0]      wr_addr;
    logic [C_PW-1:0] wr_data;
    logic            out_valid;
    logic            out_ready;
    logic [C_PW-1:0] out_top;
    logic [C_PW-1:0] out_mid;
    logic [C_PW-1:0] out_bot;
    logic [1:0]      out_col;
    logic [1:0]      out_row;
    logic            out_eof;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];
    vec_t tbl[16];
    logic [7:0] hist[4][4];
    logic [1:0] mrow = '0;
    logic [1:0] mcol = '0;
    logic lat_arm = 1'b0, lat_seen = 1'b0, acc_seen = 1'b0, stall_done = 1'b0;
    int   acc_cyc = 0, out_cyc = 0;
    logic [C_PW-1:0] mem0[4];
    logic [C_PW-1:0] mem1[4];

    sobel_linebuf_ctrl #(.pix_w_p(C_PW), .width_p(C_W), .height_p(C_H)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_sof_i(in_sof),
        .ram_rd_addr_o(rd_addr), .ram0_rd_data_i(rd0), .ram1_rd_data_i(rd1),
        .ram0_wr_valid_o(wr0), .ram1_wr_valid_o(wr1),
        .ram_wr_addr_o(wr_addr), .ram_wr_data_o(wr_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_top_o(out_top), .out_mid_o(out_mid), .out_bot_o(out_bot),
        .out_col_o(out_col), .out_row_o(out_row), .out_eof_o(out_eof)
    );

    // external line buffers: synchronous read, read-before-write
    always_ff @(posedge clk) begin
        if (wr0) mem0[wr_addr] <= wr_data;
        if (wr1) mem1[wr_addr] <= wr_data;
        rd0 <= mem0[rd_addr];
        rd1 <= mem1[rd_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // output monitor / scoreboard consumer
    initial forever begin
        @(negedge clk);
        if (lat_arm && !lat_seen && out_valid) begin
            lat_seen = 1'b1;
            out_cyc  = cyc;
        end
        if (reset_ni && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: actual=%0h required=none",
                         {out_top, out_mid, out_bot, out_col, out_row, out_eof});
            end else begin
                chk("out_column", {out_top, out_mid, out_bot, out_col, out_row, out_eof},
                    sb.pop_front());
            end
        end
    end

    task automatic send_pix(input logic [7:0] d, input logic sof, input logic use_tbl,
                            input exp_t tex);
        int   n;
        int   r;
        int   c;
        exp_t me;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 required=1");
        end else begin
            if (lat_arm && !acc_seen) begin
                acc_seen = 1'b1;
                acc_cyc  = cyc;
            end
            r = sof ? 0 : int'(mrow);
            c = sof ? 0 : int'(mcol);
            me.top = (r >= 2) ? hist[r-2][c] : 8'd0;
            me.mid = (r >= 1) ? hist[r-1][c] : 8'd0;
            me.bot = d;
            me.col = 2'(c);
            me.row = 2'(r);
            me.eof = (r == C_H-1) && (c == C_W-1);
            hist[r][c] = d;
            if (c == C_W-1) begin
                mcol = '0;
                mrow = (r == C_H-1) ? 2'd0 : 2'(r + 1);
            end else begin
                mcol = 2'(c + 1);
                mrow = 2'(r);
            end
            sb.push_back(use_tbl ? tex : me);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].data    = 8'(i + 1);
            tbl[i].exp.top = (i / 4 >= 2) ? 8'(i + 1 - 8) : 8'd0;
            tbl[i].exp.mid = (i / 4 >= 1) ? 8'(i + 1 - 4) : 8'd0;
            tbl[i].exp.bot = 8'(i + 1);
            tbl[i].exp.col = 2'(i % 4);
            tbl[i].exp.row = 2'(i / 4);
            tbl[i].exp.eof = (i == 15);
        end

        reset_ni  = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_wr0", 64'(wr0), 64'd0);
        chk("rst_wr1", 64'(wr1), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_out_data", {out_top, out_mid, out_bot, out_col, out_row, out_eof}, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset_ni = 1'b1;

        // frame A: continuous stream against the constant table
        lat_arm = 1'b1;
        for (int i = 0; i < 16; i++) send_pix(tbl[i].data, 1'b0, 1'b1, tbl[i].exp);
        drain();
        lat_arm = 1'b0;
        chk("latency_seen", 64'(lat_seen), 64'd1);
        chk("latency_cycles", 64'(out_cyc - acc_cyc), 64'd2);

        // frame B: downstream stall while row 2 col 1 is presented
        fork
            begin
                int n;
                n = 0;
                while (!(out_valid && out_row == 2'd2 && out_col == 2'd1) && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    chk("stall_no_write", {wr0, wr1}, 64'd0);
                    chk("stall_hold", {out_valid, out_top, out_mid, out_bot},
                        {1'b1, 8'd2, 8'd6, 8'd10});
                end
                @(posedge clk);
                #1;
                out_ready  = 1'b1;
                stall_done = 1'b1;
            end
        join_none
        for (int i = 1; i <= 16; i++) send_pix(8'(i), 1'b0, 1'b0, '0);
        drain();
        chk("stall_done", 64'(stall_done), 64'd1);

        // frame C: directly following, sof on first pixel
        for (int i = 0; i < 16; i++) send_pix(8'(101 + i), (i == 0), 1'b0, '0);
        drain();

        // frame D: valid every other cycle
        for (int i = 1; i <= 16; i++) begin
            send_pix(8'(i), 1'b0, 1'b0, '0);
            @(posedge clk);
            #1;
        end
        drain();

        // reset asserted mid-frame once row 2 col 2 has been taken
        for (int i = 1; i <= 11; i++) send_pix(8'(i), 1'b0, 1'b0, '0);
        reset_ni = 1'b0;
        sb.delete();
        mrow = '0;
        mcol = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_no_write", {wr0, wr1}, 64'd0);
            chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        for (int i = 1; i <= 16; i++) send_pix(8'(i), 1'b0, 1'b0, '0);
        drain();

        // spurious sof at row 1 col 3 restarts the frame
        for (int i = 1; i <= 23; i++) send_pix(8'(i), (i == 8), 1'b0, '0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
